bsg_counter_overflow_event_gen: RTL and testbench
=================================================

Name: bsg_counter_overflow_event_gen

Overview:
Sits directly downstream of the overflow/set/enable counter and consumes its overflow_o tick.
Each overflow cycle becomes one numbered "epoch" event, delivered to a consumer over a valid/ready handshake.
Up to pending_max_p undelivered events are buffered and drops are flagged, so a slow consumer never loses track of the tick count silently.
Epoch numbers are consecutive, so the buffer is a pending counter rather than a data FIFO.

Parameters:
epoch_width_p, 16, width of the epoch number; epoch wraps modulo 2^epoch_width_p.
pending_max_p, 7, maximum buffered undelivered events; legal range 1 .. 2^epoch_width_p - 1.

Ports:
clk_i  in  1  sole clock; all state updates on its rising edge.
reset_n_i  in  1  reset; synchronous, active-low.
overflow_i  in  1  counter overflow tick; each high cycle is one event.
clear_i  in  1  synchronous flush of pending events, epoch and drop flag.
v_o  out  1  event valid.
epoch_o  out  epoch_width_p  epoch number of the oldest undelivered event.
ready_i  in  1  consumer accepts the event; fire = v_o & ready_i.
pending_o  out  clog2(pending_max_p+1)  count of undelivered events.
dropped_o  out  1  sticky: at least one event was discarded because the buffer was full.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. It is sampled on clk_i only.
- Reset values, while reset_n_i=0 and the cycle after: epoch_r=0, pending_r=0, v_o=0, epoch_o=0, pending_o=0, dropped_o=0.
- Reset has top priority. Asserting it mid-stream discards all pending events with no partial delivery.
- State:
  - epoch_r = number of accepted events, modulo 2^epoch_width_p.
  - pending_r = number of accepted but undelivered events.
- Outputs, all derived from registers only; no combinational path from ready_i or overflow_i to any output:
  - v_o = (pending_r != 0).
  - pending_o = pending_r.
  - epoch_o = (epoch_r - pending_r) mod 2^epoch_width_p; drive 0 when pending_r = 0.
- Latency: overflow_i high in cycle t gives v_o high in cycle t+1, when the buffer was empty.
- Accept condition: overflow_i=1 and (pending_r < pending_max_p or fire).
  - Effect: epoch_r += 1, with wrap.
- Priority, evaluated each cycle after reset; the first matching row wins:
  1. clear_i=1: epoch_r=0, pending_r=0, dropped_o=0. Overflow and fire in this cycle are ignored; a fire in this cycle is still a completed transfer from the consumer's view.
  2. Accept and fire: pending_r unchanged; epoch_r increments.
  3. Accept, no fire: pending_r += 1.
  4. Fire, no overflow: pending_r -= 1.
  5. overflow_i=1, pending_r = pending_max_p, no fire: drop the newest event. epoch_r and pending_r are unchanged; dropped_o is set to 1 and stays 1 until clear_i or reset.
- Handshake rules:
  - v_o never deasserts without a fire, except on clear_i or reset.
  - epoch_o is stable while v_o & ~ready_i. New overflows do not change the oldest event.
  - ready_i is ignored while v_o=0.
- Wrap-around: epoch_r wraps from 2^epoch_width_p-1 to 0. epoch_o subtraction is modular, so delivered epochs stay consecutive across the wrap.
- Full boundary: with pending_r = pending_max_p, an overflow coincident with fire is accepted (no drop).
- Empty boundary: with pending_r = 0, fire cannot occur, so pending_r never underflows.

Test Plan:
- Reset, then single overflow_i pulse with ready_i=1 -> v_o=1 for exactly one cycle at t+1 with epoch_o=0. Afterwards pending_o=0 and internal epoch is 1.
- ready_i=0, 3 overflow pulses -> pending_o=3 and epoch_o=0 held stable. Then ready_i=1 -> epochs 0,1,2 delivered on consecutive cycles, then v_o=0.
- ready_i=0, 9 overflow pulses (pending_max_p=7) -> pending_o=7 and dropped_o=1. Draining yields epochs 0..6; the next overflow yields epoch 7, confirming the two drops did not advance the epoch.
- pending_o=7, ready_i=1, overflow_i=1 in the same cycle -> no drop, pending_o stays 7, epoch_o advances by 1.
- Preload 65534 accepted events (epoch_width_p=16) with immediate delivery, then 3 more while ready_i=0 -> drained epochs are 65534, 65535, 0.
- clear_i asserted with pending_o=4, dropped_o=1 and overflow_i=1 -> next cycle v_o=0, pending_o=0, dropped_o=0; the next overflow delivers epoch 0. Repeat the same setup with reset_n_i=0 instead of clear_i -> identical result.

Source files
------------

// File: rtl/bsg_counter_overflow_event_gen.sv
// Turns counter overflow ticks into consecutive epoch events on a valid/ready port.
// Epoch numbers are consecutive, so only a pending count is buffered instead of a data FIFO.
module bsg_counter_overflow_event_gen #(
    parameter int epoch_width_p = 16,
    parameter int pending_max_p = 7,
    localparam int pending_width_lp = $clog2(pending_max_p + 1)
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        overflow_i,
    input  logic                        clear_i,
    output logic                        v_o,
    output logic [epoch_width_p-1:0]    epoch_o,
    input  logic                        ready_i,
    output logic [pending_width_lp-1:0] pending_o,
    output logic                        dropped_o
);

    localparam logic [pending_width_lp-1:0] pending_max_lp = pending_width_lp'(pending_max_p);

    logic [epoch_width_p-1:0]    epoch_q,   epoch_d;
    logic [pending_width_lp-1:0] pending_q, pending_d;
    logic                        dropped_q, dropped_d;
    logic                        fire;
    logic                        accept;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        epoch_d   = epoch_q;
        pending_d = pending_q;
        dropped_d = dropped_q;

        fire   = (pending_q != '0) & ready_i;
        accept = overflow_i & ((pending_q < pending_max_lp) | fire);

        if (clear_i) begin
            epoch_d   = '0;
            pending_d = '0;
            dropped_d = 1'b0;
        end else begin
            if (accept) begin
                epoch_d = epoch_q + epoch_width_p'(1);
            end
            if (accept && !fire) begin
                pending_d = pending_q + pending_width_lp'(1);
            end else if (fire && !overflow_i) begin
                pending_d = pending_q - pending_width_lp'(1);
            end
            // A full buffer without a coincident fire discards the newest tick.
            if (overflow_i && !accept) begin
                dropped_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state flops use non-blocking assignments; reset is synchronous and sampled only here.
        if (!reset_n_i) begin
            epoch_q   <= '0;
            pending_q <= '0;
            dropped_q <= 1'b0;
        end else begin
            epoch_q   <= epoch_d;
            pending_q <= pending_d;
            dropped_q <= dropped_d;
        end
    end

    // Oldest undelivered epoch is the accept count minus what is still pending, modulo the width.
    assign v_o       = (pending_q != '0);
    assign epoch_o   = v_o ? (epoch_q - epoch_width_p'(pending_q)) : '0;
    assign pending_o = pending_q;
    assign dropped_o = dropped_q;

endmodule

// File: tb/tb_bsg_counter_overflow_event_gen.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-of-epochs model.
module tb_bsg_counter_overflow_event_gen;

    localparam int EW   = 16;
    localparam int PMAX = 7;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int OW   = EW + PW + 2;

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b0;
    logic          overflow_i = 1'b0;
    logic          clear_i = 1'b0;
    logic          ready_i = 1'b0;
    logic          v_o;
    logic [EW-1:0] epoch_o;
    logic [PW-1:0] pending_o;
    logic          dropped_o;

    int n_checks = 0;
    int n_errors = 0;

    // Model: queue of undelivered epoch numbers, running accept count, sticky drop flag.
    logic [EW-1:0] model_q[$];
    logic [EW-1:0] model_cnt = '0;
    logic          model_drop = 1'b0;

    bsg_counter_overflow_event_gen #(
        .epoch_width_p(EW),
        .pending_max_p(PMAX)
    ) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .overflow_i(overflow_i),
        .clear_i   (clear_i),
        .v_o       (v_o),
        .epoch_o   (epoch_o),
        .ready_i   (ready_i),
        .pending_o (pending_o),
        .dropped_o (dropped_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [OW-1:0] model_out();
        logic [EW-1:0] head;
        head = (model_q.size() > 0) ? model_q[0] : '0;
        return {model_q.size() > 0, head, PW'(model_q.size()), model_drop};
    endfunction

    function automatic logic [OW-1:0] dut_out();
        return {v_o, epoch_o, pending_o, dropped_o};
    endfunction

    // Drive one cycle of inputs, advance the model, and land #1 after the rising edge.
    task automatic step(input logic ov, input logic rd, input logic clr, input logic rst_n);
        overflow_i = ov;
        ready_i    = rd;
        clear_i    = clr;
        reset_n_i  = rst_n;
        if (!rst_n || clr) begin
            model_q.delete();
            model_cnt  = '0;
            model_drop = 1'b0;
        end else begin
            if (rd && model_q.size() > 0) void'(model_q.pop_front());
            if (ov) begin
                if (model_q.size() < PMAX) begin
                    model_q.push_back(model_cnt);
                    model_cnt = model_cnt + 1'b1;
                end else begin
                    model_drop = 1'b1;
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, (i == 2));
            n_checks++;
            if (dut_out() !== {OW{1'b0}}) begin
                n_errors++;
                $display("FAIL reset cycle %0d: got v=%b epoch=%0d pend=%0d drop=%b, want all zero",
                         i, v_o, epoch_o, pending_o, dropped_o);
            end
        end
    endtask

    task automatic test_single();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (!(v_o === 1'b1 && epoch_o === 16'd0 && pending_o === 3'd1)) begin
            n_errors++;
            $display("FAIL single_pulse: got v=%b epoch=%0d pend=%0d, want v=1 epoch=0 pend=1",
                     v_o, epoch_o, pending_o);
        end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (!(v_o === 1'b0 && pending_o === 3'd0)) begin
            n_errors++;
            $display("FAIL single_drain: got v=%b pend=%0d, want v=0 pend=0", v_o, pending_o);
        end
        // Internal epoch is now 1, visible through the next event.
        step(1'b1, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (!(v_o === 1'b1 && epoch_o === 16'd1)) begin
            n_errors++;
            $display("FAIL single_next_epoch: got v=%b epoch=%0d, want v=1 epoch=1", v_o, epoch_o);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (!(pending_o === 3'd3 && epoch_o === 16'd0 && v_o === 1'b1)) begin
            n_errors++;
            $display("FAIL b2b_hold: got pend=%0d epoch=%0d v=%b, want pend=3 epoch=0 v=1",
                     pending_o, epoch_o, v_o);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (!(v_o === 1'b1 && epoch_o === EW'(i))) begin
                n_errors++;
                $display("FAIL b2b_deliver %0d: got v=%b epoch=%0d, want v=1 epoch=%0d",
                         i, v_o, epoch_o, i);
            end
            step(1'b0, 1'b1, 1'b0, 1'b1);
        end
        n_checks++;
        if (v_o !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_empty: got v=%b, want 0", v_o);
        end
    endtask

    task automatic test_drop();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (!(pending_o === 3'd7 && dropped_o === 1'b1)) begin
            n_errors++;
            $display("FAIL drop_full: got pend=%0d drop=%b, want pend=7 drop=1", pending_o, dropped_o);
        end
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (!(v_o === 1'b1 && epoch_o === EW'(i))) begin
                n_errors++;
                $display("FAIL drop_drain %0d: got v=%b epoch=%0d, want v=1 epoch=%0d",
                         i, v_o, epoch_o, i);
            end
            step(1'b0, 1'b1, 1'b0, 1'b1);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (!(v_o === 1'b1 && epoch_o === 16'd7 && dropped_o === 1'b1)) begin
            n_errors++;
            $display("FAIL drop_next_epoch: got v=%b epoch=%0d drop=%b, want v=1 epoch=7 drop=1",
                     v_o, epoch_o, dropped_o);
        end
    endtask

    task automatic test_full_fire();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (!(pending_o === 3'd7 && epoch_o === 16'd1 && dropped_o === 1'b0)) begin
            n_errors++;
            $display("FAIL full_fire: got pend=%0d epoch=%0d drop=%b, want pend=7 epoch=1 drop=0",
                     pending_o, epoch_o, dropped_o);
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65534; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            logic [EW-1:0] want;
            want = EW'(65534 + i);
            n_checks++;
            if (!(v_o === 1'b1 && epoch_o === want)) begin
                n_errors++;
                $display("FAIL wrap_drain %0d: got v=%b epoch=%0d, want v=1 epoch=%0d",
                         i, v_o, epoch_o, want);
            end
            step(1'b0, 1'b1, 1'b0, 1'b1);
        end
    endtask

    // Same setup flushed by clear_i (use_reset=0) or by reset (use_reset=1).
    task automatic test_flush(input logic use_reset);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (!(pending_o === 3'd4 && dropped_o === 1'b1)) begin
            n_errors++;
            $display("FAIL flush_setup rst=%b: got pend=%0d drop=%b, want pend=4 drop=1",
                     use_reset, pending_o, dropped_o);
        end
        step(1'b1, 1'b1, !use_reset, !use_reset);
        n_checks++;
        if (!(v_o === 1'b0 && pending_o === 3'd0 && dropped_o === 1'b0)) begin
            n_errors++;
            $display("FAIL flush rst=%b: got v=%b pend=%0d drop=%b, want 0 0 0",
                     use_reset, v_o, pending_o, dropped_o);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (!(v_o === 1'b1 && epoch_o === 16'd0)) begin
            n_errors++;
            $display("FAIL flush_next rst=%b: got v=%b epoch=%0d, want v=1 epoch=0",
                     use_reset, v_o, epoch_o);
        end
    endtask

    task automatic test_random();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            logic ov, rd, clr, rst_n;
            ov    = ($urandom_range(0, 3) != 0);
            rd    = ($urandom_range(0, 2) == 0);
            clr   = ($urandom_range(0, 63) == 0);
            rst_n = ($urandom_range(0, 127) != 0);
            step(ov, rd, clr, rst_n);
            n_checks++;
            if (dut_out() !== model_out()) begin
                n_errors++;
                $display("FAIL random cycle %0d: got {v,epoch,pend,drop}=%h, want %h",
                         i, dut_out(), model_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_drop();
        test_full_fire();
        test_wrap();
        test_flush(1'b0);
        test_flush(1'b1);
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
